// File: rtl/sync_fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Grants are held for bursts of up to MAX_BURST beats; full stalls the burst.
module sync_fifo_write_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 8,
  parameter int IDX_BITS   = $clog2(NUM_REQ),
  parameter int CNT_BITS   = $clog2(MAX_BURST+1)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic [IDX_BITS-1:0]           grant_idx_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_REQ =
    IDX_BITS'(NUM_REQ - 1);
  localparam logic [CNT_BITS-1:0] LAST_BEAT =
    CNT_BITS'(MAX_BURST - 1);

  state_t                state;
  logic [IDX_BITS-1:0]   last_idx;
  logic [IDX_BITS-1:0]   grant_idx;
  logic [NUM_REQ-1:0]    grant;
  logic [CNT_BITS-1:0]   beat_cnt;

  logic [IDX_BITS-1:0]   pick_idx;
  logic [IDX_BITS-1:0]   cand;
  logic                  pick_vld;
  logic                  cur_req;
  logic                  accept;
  logic                  last_beat;
  logic                  burst_end;

  logic [DATA_WIDTH-1:0] beats [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_beat
    assign beats[k] = data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Walk offsets from far to near so the nearest requester
  // after last_idx is the one left in pick_idx.
  always_comb begin
    pick_idx = last_idx;
    pick_vld = 1'b0;
    cand     = last_idx;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_BITS'((int'(last_idx) + k) % NUM_REQ);
      if (req_i[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  assign cur_req   = req_i[grant_idx];
  assign accept    = rst_n_i && (state == BURST) &&
                     cur_req && !fifo_full_i;
  assign last_beat = (beat_cnt == LAST_BEAT);
  assign burst_end = !cur_req || (accept && last_beat);

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= LAST_REQ;
      last_idx  <= LAST_REQ;
      beat_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            state     <= BURST;
            grant     <= NUM_REQ'(1) << pick_idx;
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
          end
        end
        BURST: begin
          if (burst_end) begin
            state    <= IDLE;
            grant    <= '0;
            last_idx <= grant_idx;
            beat_cnt <= '0;
          end else if (accept) begin
            beat_cnt <= beat_cnt + CNT_BITS'(1);
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign ack_o        = accept ? grant : '0;
  assign fifo_wr_en_o = accept;
  assign fifo_data_o  = beats[grant_idx];
  assign grant_o      = grant;
  assign grant_idx_o  = grant_idx;
  assign busy_o       = (state == BURST);

endmodule

// File: tb/tb_sync_fifo_write_arbiter.sv
// Bench for sync_fifo_write_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_sync_fifo_write_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR-1:0]          req;
  logic [NR-1:0][DW-1:0]  data;
  logic [NR-1:0]          ack;
  logic [NR-1:0]          grant;
  logic [1:0]             gidx;
  logic                   full;
  logic                   wr;
  logic [DW-1:0]          fdata;
  logic                   busy;

  always #5 clk = ~clk;

  sync_fifo_write_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_i       (req),
    .data_i      (data),
    .ack_o       (ack),
    .grant_o     (grant),
    .grant_idx_o (gidx),
    .fifo_full_i (full),
    .fifo_wr_en_o(wr),
    .fifo_data_o (fdata),
    .busy_o      (busy)
  );

  int checks = 0;
  int errors = 0;

  logic          rst_drv;
  logic [NR-1:0] req_drv;
  logic          full_drv;

  int seq   [NR];
  int waits [NR];
  int owner;
  int taken;
  int prev;
  int shown;
  int acks;
  int glog [$];
  logic gprev;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] ix(input int v);
    return v[1:0];
  endfunction

  function automatic logic [DW-1:0] slice(input int k);
    int s;
    s = seq[ix(k)];
    return {k[1:0], s[5:0]};
  endfunction

  task automatic step();
    logic acc;
    int   d;
    int   nxt;
    @(negedge clk);
    rst_n = rst_drv;
    req   = req_drv;
    full  = full_drv;
    for (int k = 0; k < NR; k++) data[ix(k)] = slice(k);
    #1;
    acc = rst_drv && owner >= 0 && !full_drv &&
          req_drv[ix(owner)];
    check("busy", 64'(busy), 64'(owner >= 0));
    check("grant", 64'(grant),
          owner >= 0 ? (64'd1 << owner) : 64'd0);
    check("gidx", 64'(gidx), 64'(shown));
    check("ack", 64'(ack), acc ? (64'd1 << owner) : 64'd0);
    check("wr_en", 64'(wr), 64'(acc));
    check("data", 64'(fdata), 64'(slice(shown)));
    check("no_ovf", 64'(wr && full), 64'd0);
    if (ack != '0) acks++;
    if (grant != '0 && !gprev) glog.push_back(int'(gidx));
    gprev = (grant != '0);

    for (int k = 0; k < NR; k++)
      if (!req_drv[ix(k)] || !rst_drv) waits[ix(k)] = 0;

    if (!rst_drv) begin
      owner = -1;
      taken = 0;
      prev  = NR - 1;
      shown = NR - 1;
    end else if (owner < 0) begin
      if (req_drv != '0) begin
        d = 1;
        while (!req_drv[ix((prev + d) % NR)]) d++;
        nxt = (prev + d) % NR;
        for (int k = 0; k < NR; k++) begin
          if (k == nxt) begin
            waits[ix(k)] = 0;
          end else if (req_drv[ix(k)]) begin
            waits[ix(k)]++;
            check("fair", 64'(waits[ix(k)] > NR - 1), 64'd0);
          end
        end
        owner = nxt;
        shown = nxt;
        taken = 0;
      end
    end else if (!req_drv[ix(owner)]) begin
      prev  = owner;
      owner = -1;
    end else if (!full_drv) begin
      seq[ix(owner)]++;
      taken++;
      if (taken == MB) begin
        prev  = owner;
        owner = -1;
      end
    end
    @(posedge clk);
  endtask

  initial begin
    int exp_g [5] = '{0, 1, 2, 3, 0};

    rst_drv  = 1'b0;
    req_drv  = '0;
    full_drv = 1'b0;
    rst_n    = 1'b0;
    req      = '0;
    full     = 1'b0;
    data     = '0;
    for (int k = 0; k < NR; k++) begin
      seq[ix(k)]   = 0;
      waits[ix(k)] = 0;
    end
    owner = -1;
    taken = 0;
    prev  = NR - 1;
    shown = NR - 1;
    gprev = 1'b0;
    acks  = 0;
    repeat (2) @(posedge clk);

    rst_drv = 1'b1;
    step();

    // all four requesting from reset
    req_drv = 4'b1111;
    acks = 0;
    glog.delete();
    repeat (25) step();
    check("rr_acks", 64'(acks), 64'd20);
    check("rr_bursts", 64'(glog.size()), 64'd5);
    for (int i = 0; i < 5 && i < glog.size(); i++)
      check("rr_order", 64'(glog[i]), 64'(exp_g[i]));
    req_drv = '0;
    step();

    // full stall in the middle of producer 2's burst
    req_drv = 4'b0100;
    acks = 0;
    repeat (3) step();
    full_drv = 1'b1;
    repeat (3) step();
    full_drv = 1'b0;
    repeat (2) step();
    check("stall_acks", 64'(acks), 64'd4);
    req_drv = '0;
    step();

    // early release by producer 1
    req_drv = 4'b0010;
    glog.delete();
    repeat (3) step();
    req_drv = 4'b0001;
    step();
    req_drv = 4'b0011;
    step();
    step();
    check("rel_grants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      check("rel_first", 64'(glog[0]), 64'd1);
      check("rel_next", 64'(glog[1]), 64'd0);
    end
    req_drv = '0;
    repeat (2) step();

    // lone requester
    req_drv = 4'b1000;
    acks = 0;
    repeat (25) step();
    check("single_acks", 64'(acks), 64'd20);
    req_drv = '0;
    step();

    // reset in the middle of a burst
    req_drv = 4'b0001;
    acks = 0;
    glog.delete();
    repeat (2) step();
    rst_drv = 1'b0;
    step();
    rst_drv = 1'b1;
    repeat (5) step();
    check("rst_acks", 64'(acks), 64'd5);
    check("rst_grants", 64'(glog.size()), 64'd2);
    if (glog.size() == 2)
      check("rst_regrant", 64'(glog[1]), 64'd0);
    req_drv = '0;
    step();

    // random traffic
    for (int n = 0; n < 10000; n++) begin
      for (int k = 0; k < NR; k++) begin
        if (req_drv[ix(k)])
          req_drv[ix(k)] = ($urandom_range(0, 15) != 0);
        else
          req_drv[ix(k)] = ($urandom_range(0, 1) != 0);
      end
      full_drv = ($urandom_range(0, 3) == 0);
      rst_drv  = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
